mem_port_arbiter: RTL and testbench



---
 rtl/mem_arb_pkg.sv | 19 +
 rtl/mem_port_arbiter_rr_pick2.sv | 27 ++
 rtl/mem_port_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and default sizes for the tinyV unified memory-port arbiter.
package mem_arb_pkg;

   localparam int unsigned DEF_ADDR_WIDTH     = 32;
   localparam int unsigned DEF_DATA_WIDTH     = 32;
   localparam int unsigned DEF_TIMEOUT_CYCLES = 255;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GRANT_I = 2'd1,
      GRANT_D = 2'd2
   } arb_state_t;

   typedef enum logic {
      GRANT_SIDE_I = 1'b0,
      GRANT_SIDE_D = 1'b1
   } grant_t;

endpackage

// File: rtl/mem_port_arbiter_rr_pick2.sv
// Two-way requester picker: round-robin on a tie, or data side wins when
// data_priority is set.
module rr_pick2
   import mem_arb_pkg::*;
(
   input  logic   req_i,
   input  logic   req_d,
   input  grant_t last_grant,
   input  logic   data_priority,
   output grant_t grant,
   output logic   valid
);

   always_comb begin
      grant = GRANT_SIDE_I;
      valid = req_i | req_d;
      if (req_i && req_d) begin
         // On a tie the side that did not win last time goes next.
         if (data_priority || (last_grant == GRANT_SIDE_I)) begin
            grant = GRANT_SIDE_D;
         end
      end else if (req_d) begin
         grant = GRANT_SIDE_D;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between the tinyV fetch and data interfaces, latching
// the granted request and aborting transactions the slave never acknowledges.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH     = DEF_ADDR_WIDTH,
   parameter int unsigned DATA_WIDTH     = DEF_DATA_WIDTH,
   parameter int unsigned DATA_PRIORITY  = 0,
   parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    i_req,
   input  logic [ADDR_WIDTH-1:0]   i_address,
   output logic [DATA_WIDTH-1:0]   i_data_read,
   output logic                    i_data_valid,
   input  logic                    d_req,
   input  logic [ADDR_WIDTH-1:0]   d_address,
   input  logic [DATA_WIDTH-1:0]   d_data_write,
   input  logic [DATA_WIDTH/8-1:0] d_data_wstrb,
   input  logic                    d_write_enable,
   output logic [DATA_WIDTH-1:0]   d_data_read,
   output logic                    d_data_valid,
   output logic                    m_req,
   output logic [ADDR_WIDTH-1:0]   m_address,
   output logic [DATA_WIDTH-1:0]   m_wdata,
   output logic [DATA_WIDTH/8-1:0] m_wstrb,
   output logic                    m_we,
   input  logic [DATA_WIDTH-1:0]   m_rdata,
   input  logic                    m_ready,
   output logic                    bus_error
);

   localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
   localparam int unsigned CNT_WIDTH  = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

   arb_state_t             state_q, state_d;
   grant_t                 last_grant_q, last_grant_d;
   logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
   logic                   m_req_q, m_req_d;
   logic [ADDR_WIDTH-1:0]  m_addr_q, m_addr_d;
   logic [DATA_WIDTH-1:0]  m_wdata_q, m_wdata_d;
   logic [STRB_WIDTH-1:0]  m_wstrb_q, m_wstrb_d;
   logic                   m_we_q, m_we_d;
   logic [DATA_WIDTH-1:0]  i_rdata_q, i_rdata_d;
   logic                   i_valid_q, i_valid_d;
   logic [DATA_WIDTH-1:0]  d_rdata_q, d_rdata_d;
   logic                   d_valid_q, d_valid_d;
   logic                   bus_err_q, bus_err_d;

   logic                   pick_valid;
   grant_t                 pick_side;

   // A requester still holding req during its own response cycle is not eligible.
   rr_pick2 u_pick (
      .req_i         (i_req && !i_valid_q),
      .req_d         (d_req && !d_valid_q),
      .last_grant    (last_grant_q),
      .data_priority (DATA_PRIORITY != 0),
      .grant         (pick_side),
      .valid         (pick_valid)
   );

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      cnt_d        = cnt_q;
      m_req_d      = m_req_q;
      m_addr_d     = m_addr_q;
      m_wdata_d    = m_wdata_q;
      m_wstrb_d    = m_wstrb_q;
      m_we_d       = m_we_q;
      i_rdata_d    = i_rdata_q;
      i_valid_d    = 1'b0;
      d_rdata_d    = d_rdata_q;
      d_valid_d    = 1'b0;
      bus_err_d    = 1'b0;

      case (state_q)
         IDLE: begin
            if (pick_valid) begin
               m_req_d      = 1'b1;
               cnt_d        = '0;
               last_grant_d = pick_side;
               if (pick_side == GRANT_SIDE_D) begin
                  state_d   = GRANT_D;
                  m_addr_d  = d_address;
                  m_wdata_d = d_data_write;
                  m_wstrb_d = d_data_wstrb;
                  m_we_d    = d_write_enable;
               end else begin
                  state_d   = GRANT_I;
                  m_addr_d  = i_address;
                  m_wdata_d = '0;
                  m_wstrb_d = '0;
                  m_we_d    = 1'b0;
               end
            end
         end

         GRANT_I, GRANT_D: begin
            // An acknowledge on the final watchdog cycle still completes normally.
            if (m_ready) begin
               m_req_d = 1'b0;
               state_d = IDLE;
               if (state_q == GRANT_I) begin
                  i_rdata_d = m_rdata;
                  i_valid_d = 1'b1;
               end else begin
                  d_rdata_d = m_rdata;
                  d_valid_d = 1'b1;
               end
            end else if (cnt_q == CNT_LAST) begin
               m_req_d   = 1'b0;
               state_d   = IDLE;
               bus_err_d = 1'b1;
               if (state_q == GRANT_I) begin
                  i_rdata_d = '0;
                  i_valid_d = 1'b1;
               end else begin
                  d_rdata_d = '0;
                  d_valid_d = 1'b1;
               end
            end else begin
               cnt_d = cnt_q + CNT_WIDTH'(1);
            end
         end

         default: begin
            state_d = IDLE;
            m_req_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= IDLE;
         last_grant_q <= GRANT_SIDE_D;
         cnt_q        <= '0;
         m_req_q      <= 1'b0;
         m_addr_q     <= '0;
         m_wdata_q    <= '0;
         m_wstrb_q    <= '0;
         m_we_q       <= 1'b0;
         i_rdata_q    <= '0;
         i_valid_q    <= 1'b0;
         d_rdata_q    <= '0;
         d_valid_q    <= 1'b0;
         bus_err_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         cnt_q        <= cnt_d;
         m_req_q      <= m_req_d;
         m_addr_q     <= m_addr_d;
         m_wdata_q    <= m_wdata_d;
         m_wstrb_q    <= m_wstrb_d;
         m_we_q       <= m_we_d;
         i_rdata_q    <= i_rdata_d;
         i_valid_q    <= i_valid_d;
         d_rdata_q    <= d_rdata_d;
         d_valid_q    <= d_valid_d;
         bus_err_q    <= bus_err_d;
      end
   end

   assign m_req        = m_req_q;
   assign m_address    = m_addr_q;
   assign m_wdata      = m_wdata_q;
   assign m_wstrb      = m_wstrb_q;
   assign m_we         = m_we_q;
   assign i_data_read  = i_rdata_q;
   assign i_data_valid = i_valid_q;
   assign d_data_read  = d_rdata_q;
   assign d_data_valid = d_valid_q;
   assign bus_error    = bus_err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus random
// traffic compared cycle by cycle against a transaction-level reference model.
module tb_mem_port_arbiter;

   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;
   localparam int unsigned SW = DW / 8;
   localparam int unsigned TO = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // main instance: round-robin, short watchdog
   logic          reset;
   logic          i_req, i_data_valid;
   logic [AW-1:0] i_address;
   logic [DW-1:0] i_data_read;
   logic          d_req, d_write_enable, d_data_valid;
   logic [AW-1:0] d_address;
   logic [DW-1:0] d_data_write, d_data_read;
   logic [SW-1:0] d_data_wstrb;
   logic          m_req, m_we, m_ready, bus_error;
   logic [AW-1:0] m_address;
   logic [DW-1:0] m_wdata, m_rdata;
   logic [SW-1:0] m_wstrb;

   mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DATA_PRIORITY(0), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .reset(reset),
      .i_req(i_req), .i_address(i_address), .i_data_read(i_data_read), .i_data_valid(i_data_valid),
      .d_req(d_req), .d_address(d_address), .d_data_write(d_data_write), .d_data_wstrb(d_data_wstrb),
      .d_write_enable(d_write_enable), .d_data_read(d_data_read), .d_data_valid(d_data_valid),
      .m_req(m_req), .m_address(m_address), .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_we(m_we),
      .m_rdata(m_rdata), .m_ready(m_ready), .bus_error(bus_error)
   );

   // second instance: data side wins ties
   logic          p_reset;
   logic          p_i_req, p_i_data_valid;
   logic [AW-1:0] p_i_address;
   logic [DW-1:0] p_i_data_read;
   logic          p_d_req, p_d_write_enable, p_d_data_valid;
   logic [AW-1:0] p_d_address;
   logic [DW-1:0] p_d_data_write, p_d_data_read;
   logic [SW-1:0] p_d_data_wstrb;
   logic          p_m_req, p_m_we, p_m_ready, p_bus_error;
   logic [AW-1:0] p_m_address;
   logic [DW-1:0] p_m_wdata, p_m_rdata;
   logic [SW-1:0] p_m_wstrb;

   mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DATA_PRIORITY(1), .TIMEOUT_CYCLES(255)) dut_p (
      .clk(clk), .reset(p_reset),
      .i_req(p_i_req), .i_address(p_i_address), .i_data_read(p_i_data_read), .i_data_valid(p_i_data_valid),
      .d_req(p_d_req), .d_address(p_d_address), .d_data_write(p_d_data_write), .d_data_wstrb(p_d_data_wstrb),
      .d_write_enable(p_d_write_enable), .d_data_read(p_d_data_read), .d_data_valid(p_d_data_valid),
      .m_req(p_m_req), .m_address(p_m_address), .m_wdata(p_m_wdata), .m_wstrb(p_m_wstrb), .m_we(p_m_we),
      .m_rdata(p_m_rdata), .m_ready(p_m_ready), .bus_error(p_bus_error)
   );

   int unsigned n_vec = 0;
   int unsigned n_err = 0;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Reference model: side in service (0 none, 1 fetch, 2 data), the side
   // served last, and how many cycles the current m_req has been up.
   int            cur, last, age;
   logic          e_mreq, e_mwe, e_iv, e_dv, e_berr;
   logic [AW-1:0] e_maddr;
   logic [DW-1:0] e_mwdata, e_ird, e_drd;
   logic [SW-1:0] e_mstrb;

   task automatic model_reset();
      cur = 0; last = 2; age = 0;
      e_mreq = 1'b0; e_mwe = 1'b0; e_iv = 1'b0; e_dv = 1'b0; e_berr = 1'b0;
      e_maddr = '0; e_mwdata = '0; e_ird = '0; e_drd = '0; e_mstrb = '0;
   endtask

   // Predict outputs after the coming rising edge from the inputs now applied.
   task automatic model_step();
      logic ei, ed;
      int   side;
      ei = i_req && !e_iv;
      ed = d_req && !e_dv;
      e_iv = 1'b0; e_dv = 1'b0; e_berr = 1'b0;
      if (cur == 0) begin
         if (ei || ed) begin
            if (ei && ed) side = (last == 1) ? 2 : 1;
            else          side = ed ? 2 : 1;
            cur = side; last = side; age = 1; e_mreq = 1'b1;
            if (side == 2) begin
               e_maddr = d_address; e_mwdata = d_data_write; e_mstrb = d_data_wstrb; e_mwe = d_write_enable;
            end else begin
               e_maddr = i_address; e_mwdata = '0; e_mstrb = '0; e_mwe = 1'b0;
            end
         end
      end else if (m_ready || age == int'(TO)) begin
         if (cur == 1) begin e_iv = 1'b1; e_ird = m_ready ? m_rdata : '0; end
         else          begin e_dv = 1'b1; e_drd = m_ready ? m_rdata : '0; end
         e_berr = !m_ready;
         cur = 0; e_mreq = 1'b0;
      end else begin
         age++;
      end
   endtask

   task automatic check_all();
      chk("m_req", 128'(m_req), 128'(e_mreq));
      chk("m_cmd", 128'({m_address, m_wdata, m_wstrb, m_we}), 128'({e_maddr, e_mwdata, e_mstrb, e_mwe}));
      chk("i_resp", 128'({i_data_valid, i_data_read}), 128'({e_iv, e_ird}));
      chk("d_resp", 128'({d_data_valid, d_data_read}), 128'({e_dv, e_drd}));
      chk("bus_error", 128'(bus_error), 128'(e_berr));
   endtask

   task automatic tick();
      model_step();
      @(negedge clk);
      check_all();
   endtask

   logic i_pend, d_pend;

   // Requesters hold req until their valid; the slave acks at random.
   task automatic drive_random();
      if (i_pend && i_data_valid) i_pend = 1'b0;
      if (!i_pend) begin
         if ($urandom_range(2) == 0) begin i_pend = 1'b1; i_req = 1'b1; i_address = $urandom; end
         else i_req = 1'b0;
      end else if ($urandom_range(3) == 0) begin
         i_address = $urandom;
      end
      if (d_pend && d_data_valid) d_pend = 1'b0;
      if (!d_pend) begin
         if ($urandom_range(2) == 0) begin
            d_pend = 1'b1; d_req = 1'b1; d_address = $urandom; d_data_write = $urandom;
            d_data_wstrb = SW'($urandom); d_write_enable = 1'($urandom);
         end else d_req = 1'b0;
      end else if ($urandom_range(3) == 0) begin
         d_address = $urandom; d_data_write = $urandom; d_data_wstrb = SW'($urandom);
         d_write_enable = 1'($urandom);
      end
      m_ready = ($urandom_range(2) == 0);
      m_rdata = $urandom;
   endtask

   initial begin
      int seen;
      int exp_side[4] = '{2, 1, 2, 1};
      reset = 1'b0; p_reset = 1'b0;
      i_req = 1'b0; i_address = '0; d_req = 1'b0; d_address = '0; d_data_write = '0;
      d_data_wstrb = '0; d_write_enable = 1'b0; m_ready = 1'b0; m_rdata = '0;
      p_i_req = 1'b0; p_i_address = '0; p_d_req = 1'b0; p_d_address = '0; p_d_data_write = '0;
      p_d_data_wstrb = '0; p_d_write_enable = 1'b0; p_m_ready = 1'b0; p_m_rdata = '0;
      i_pend = 1'b0; d_pend = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      check_all();
      reset = 1'b1;

      // single fetch, acknowledged in the second m_req cycle
      i_req = 1'b1; i_address = 32'h100;
      tick();
      chk("fetch_addr", 128'(m_address), 128'(32'h100));
      chk("fetch_we_strb", 128'({m_we, m_wstrb}), 128'(0));
      tick();
      m_ready = 1'b1; m_rdata = 32'hDEADBEEF;
      tick();
      chk("fetch_resp", 128'({i_data_valid, i_data_read}), 128'({1'b1, 32'hDEADBEEF}));
      m_ready = 1'b0;
      tick();
      chk("mask_no_regrant", 128'(m_req), 128'(0));
      i_req = 1'b0;
      tick();

      // store
      d_req = 1'b1; d_address = 32'h2004; d_data_write = 32'h11223344; d_data_wstrb = 4'b0011;
      d_write_enable = 1'b1;
      tick();
      chk("store_cmd", 128'({m_address, m_wdata, m_wstrb, m_we}), 128'({32'h2004, 32'h11223344, 4'b0011, 1'b1}));
      m_ready = 1'b1; m_rdata = 32'h0BAD_F00D;
      tick();
      chk("store_dvalid", 128'(d_data_valid), 128'(1));
      chk("store_ivalid", 128'(i_data_valid), 128'(0));
      d_req = 1'b0; m_ready = 1'b0;
      tick();

      // watchdog abort after four unacknowledged cycles
      d_write_enable = 1'b0;
      d_req = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         tick();
         chk("timeout_mreq_high", 128'(m_req), 128'(1));
      end
      tick();
      chk("timeout_berr", 128'({bus_error, d_data_valid, d_data_read}), 128'({1'b1, 1'b1, 32'h0}));
      d_req = 1'b0;
      tick();

      // acknowledge on the final watchdog cycle wins
      d_req = 1'b1;
      repeat (4) tick();
      m_ready = 1'b1; m_rdata = 32'h5A5A;
      tick();
      chk("late_ack", 128'({bus_error, d_data_valid, d_data_read}), 128'({1'b0, 1'b1, 32'h5A5A}));
      d_req = 1'b0; m_ready = 1'b0;
      tick();

      // random traffic
      for (int n = 0; n < 4000; n++) begin
         drive_random();
         tick();
      end

      // asynchronous reset while the data side is granted
      i_req = 1'b0; d_req = 1'b0; m_ready = 1'b0;
      for (int k = 0; k < 12 && (cur != 0 || e_iv || e_dv); k++) tick();
      d_req = 1'b1; d_address = 32'h3000; d_write_enable = 1'b1;
      tick();
      i_req = 1'b1; i_address = 32'h400;
      tick();
      chk("pre_reset_grant_d", 128'({m_req, m_address}), 128'({1'b1, 32'h3000}));
      #2 reset = 1'b0;
      #1;
      chk("rst_async_m", 128'({m_req, m_address, m_wdata, m_wstrb, m_we}), 128'(0));
      chk("rst_async_resp", 128'({i_data_valid, i_data_read, d_data_valid, d_data_read, bus_error}), 128'(0));
      model_reset();
      @(negedge clk);
      check_all();
      reset = 1'b1;
      tick();
      chk("post_reset_grant_i", 128'({m_req, m_address, m_we}), 128'({1'b1, 32'h400, 1'b0}));
      i_req = 1'b0; d_req = 1'b0;

      // data-priority instance: both sides held from reset
      p_i_req = 1'b1; p_i_address = 32'hA0;
      p_d_req = 1'b1; p_d_address = 32'hB0; p_d_write_enable = 1'b1;
      @(negedge clk);
      p_reset = 1'b1;
      for (int t = 0; t < 4; t++) begin
         seen = 0;
         for (int w = 0; w < 8 && !p_m_req; w++) @(negedge clk);
         chk("prio_grant_seen", 128'(p_m_req), 128'(1));
         if (p_m_req) seen = (p_m_address == 32'hB0) ? 2 : 1;
         chk("prio_grant_side", 128'(seen), 128'(exp_side[t]));
         p_m_ready = 1'b1; p_m_rdata = $urandom;
         @(negedge clk);
         p_m_ready = 1'b0;
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
